// File: rtl/alarmclock_multi.sv
// alarmclock_multi: BCD HH:MM clock with a binary seconds counter, N_ALARMS alarm slots,
// a ring auto-timeout and an optional snooze.
// Optional feature macro: ALARMCLOCK_MULTI_SNOOZE_EN adds the SNOOZE state and snooze counter.
// Without it the snooze input is ignored.
// Ports:
//   alarmclock_multi_clk / _rst : clock, synchronous active-high reset
//   alarmclock_multi_en         : timekeeping enable (freezes prescaler and all second counters)
//   alarmclock_multi_set_time   : pulse, load time from set_val (invalid BCD ignored)
//   alarmclock_multi_set_alarm  : pulse, load slot sel from set_val (invalid BCD or sel ignored)
//   alarmclock_multi_sel        : alarm slot index
//   alarmclock_multi_set_val    : BCD HH:MM
//   alarmclock_multi_alarm_en   : per-slot arm bits
//   alarmclock_multi_snooze     : pulse, snooze a ringing alarm
//   alarmclock_multi_dismiss    : pulse, silence the alarm (wins over snooze)
//   alarmclock_multi_time       : current BCD HH:MM
//   alarmclock_multi_sec        : current seconds, binary
//   alarmclock_multi_tick       : one-cycle pulse per second
//   alarmclock_multi_ring       : alarm sounding
//   alarmclock_multi_ring_id    : slot that caused the ring
module alarmclock_multi #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned N_ALARMS   = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  localparam int unsigned SW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                alarmclock_multi_clk,
  input  logic                alarmclock_multi_rst,
  input  logic                alarmclock_multi_en,
  input  logic                alarmclock_multi_set_time,
  input  logic                alarmclock_multi_set_alarm,
  input  logic [SW-1:0]       alarmclock_multi_sel,
  input  logic [15:0]         alarmclock_multi_set_val,
  input  logic [N_ALARMS-1:0] alarmclock_multi_alarm_en,
  input  logic                alarmclock_multi_snooze,
  input  logic                alarmclock_multi_dismiss,
  output logic [15:0]         alarmclock_multi_time,
  output logic [5:0]          alarmclock_multi_sec,
  output logic                alarmclock_multi_tick,
  output logic                alarmclock_multi_ring,
  output logic [SW-1:0]       alarmclock_multi_ring_id
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef ALARMCLOCK_MULTI_SNOOZE_EN
  localparam int unsigned CntMax = (SNOOZE_MIN * 60 > RING_SEC) ? SNOOZE_MIN * 60 : RING_SEC;
`else
  localparam int unsigned CntMax = RING_SEC;
`endif
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] RingLoad = CntW'(RING_SEC);

`ifdef ALARMCLOCK_MULTI_SNOOZE_EN
  localparam logic [CntW-1:0] SnoozeLoad = CntW'(SNOOZE_MIN * 60);
  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;
`else
  typedef enum logic [0:0] {StIdle, StRing} state_e;
`endif

  state_e          state_q, state_d;
  logic [PrescW-1:0] presc_q;
  logic [15:0]     time_q, time_inc;
  logic [5:0]      sec_q;
  logic [15:0]     slot_q [N_ALARMS];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   ring_id_q, ring_id_d;
  logic [SW-1:0]   match_id;
  logic            tick, set_time_ok, set_alarm_ok, rollover, match, disarm;

  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[15:12] <= 4'd2) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) &&
           (v[3:0] <= 4'd9) && (v[15:8] <= 8'h23);
  endfunction

  assign tick         = alarmclock_multi_en && (presc_q == PrescW'(TICK_DIV - 1));
  assign set_time_ok  = alarmclock_multi_set_time && bcd_valid(alarmclock_multi_set_val);
  assign set_alarm_ok = alarmclock_multi_set_alarm && bcd_valid(alarmclock_multi_set_val) &&
                        (32'(alarmclock_multi_sel) < N_ALARMS);
  // A valid set_time suppresses the rollover, so loading a time can never trigger a match.
  assign rollover     = tick && !set_time_ok && (sec_q == 6'd59);
  assign disarm       = !alarmclock_multi_alarm_en[ring_id_q];

  // Next HH:MM after a minute rollover, in BCD.
  always_comb begin
    time_inc = time_q;
    if (time_q[3:0] != 4'd9) begin
      time_inc[3:0] = time_q[3:0] + 4'd1;
    end else begin
      time_inc[3:0] = 4'd0;
      if (time_q[7:4] != 4'd5) begin
        time_inc[7:4] = time_q[7:4] + 4'd1;
      end else begin
        time_inc[7:4] = 4'd0;
        if (time_q[15:8] == 8'h23) begin
          time_inc[15:8] = 8'h00;
        end else if (time_q[11:8] != 4'd9) begin
          time_inc[11:8] = time_q[11:8] + 4'd1;
        end else begin
          time_inc[11:8]  = 4'd0;
          time_inc[15:12] = time_q[15:12] + 4'd1;
        end
      end
    end
  end

  // Downward scan so the lowest armed matching slot is the one left in match_id.
  always_comb begin
    match    = 1'b0;
    match_id = '0;
    for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
      if (alarmclock_multi_alarm_en[i] && (slot_q[i] == time_inc)) begin
        match    = 1'b1;
        match_id = SW'(i);
      end
    end
  end

  // Timekeeping and alarm slot storage.
  always_ff @(posedge alarmclock_multi_clk) begin
    if (alarmclock_multi_rst) begin
      presc_q <= '0;
      time_q  <= 16'h0000;
      sec_q   <= 6'd0;
      for (int i = 0; i < int'(N_ALARMS); i++) begin
        slot_q[i] <= 16'h0000;
      end
    end else begin
      if (alarmclock_multi_en) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
      end
      if (set_time_ok) begin
        time_q  <= alarmclock_multi_set_val;
        sec_q   <= 6'd0;
        presc_q <= '0;
      end else if (tick) begin
        if (sec_q == 6'd59) begin
          sec_q  <= 6'd0;
          time_q <= time_inc;
        end else begin
          sec_q <= sec_q + 6'd1;
        end
      end
      if (set_alarm_ok) begin
        slot_q[alarmclock_multi_sel] <= alarmclock_multi_set_val;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge alarmclock_multi_clk) begin
    if (alarmclock_multi_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ring_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ring_id_q <= ring_id_d;
    end
  end

  // FSM next state; cnt_q counts seconds left in RING or SNOOZE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ring_id_d = ring_id_q;
    case (state_q)
      StIdle: begin
        if (rollover && match) begin
          state_d   = StRing;
          cnt_d     = RingLoad;
          ring_id_d = match_id;
        end
      end
      StRing: begin
        if (alarmclock_multi_dismiss || disarm) begin
          state_d = StIdle;
`ifdef ALARMCLOCK_MULTI_SNOOZE_EN
        end else if (alarmclock_multi_snooze) begin
          state_d = StSnooze;
          cnt_d   = SnoozeLoad;
`endif
        end else if (tick) begin
          if (cnt_q == CntW'(1)) state_d = StIdle;
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef ALARMCLOCK_MULTI_SNOOZE_EN
      StSnooze: begin
        if (alarmclock_multi_dismiss || disarm) begin
          state_d = StIdle;
        end else if (tick) begin
          if (cnt_q == CntW'(1)) begin
            state_d = StRing;
            cnt_d   = RingLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    alarmclock_multi_ring = (state_q == StRing);
  end

  assign alarmclock_multi_ring_id = ring_id_q;
  assign alarmclock_multi_time    = time_q;
  assign alarmclock_multi_sec     = sec_q;
  assign alarmclock_multi_tick    = tick;

endmodule

// File: tb/tb_alarmclock_multi.sv
// Bench for alarmclock_multi (TICK_DIV=4, N_ALARMS=4, SNOOZE_MIN=1, RING_SEC=10).
// Reference model keeps time as seconds-of-day and alarms as minutes-of-day.
module tb_alarmclock_multi;
  localparam int TD = 4;
  localparam int NA = 4;
  localparam int SM = 1;
  localparam int RS = 10;
  localparam int MIdle = 0;
  localparam int MRing = 1;
  localparam int MSnooze = 2;
`ifdef ALARMCLOCK_MULTI_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, set_time, set_alarm, snooze, dismiss;
  logic [1:0]  sel;
  logic [15:0] set_val;
  logic [3:0]  alarm_en;
  logic [15:0] time_w;
  logic [5:0]  sec_w;
  logic        tick_w, ring_w;
  logic [1:0]  ring_id_w;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int m_sod, m_pre, m_mode, m_cnt, m_id;
  int m_slot [NA];

  always #5 clk = ~clk;

  alarmclock_multi #(
    .TICK_DIV(TD), .N_ALARMS(NA), .SNOOZE_MIN(SM), .RING_SEC(RS)
  ) u_dut (
    .alarmclock_multi_clk      (clk),
    .alarmclock_multi_rst      (rst),
    .alarmclock_multi_en       (en),
    .alarmclock_multi_set_time (set_time),
    .alarmclock_multi_set_alarm(set_alarm),
    .alarmclock_multi_sel      (sel),
    .alarmclock_multi_set_val  (set_val),
    .alarmclock_multi_alarm_en (alarm_en),
    .alarmclock_multi_snooze   (snooze),
    .alarmclock_multi_dismiss  (dismiss),
    .alarmclock_multi_time     (time_w),
    .alarmclock_multi_sec      (sec_w),
    .alarmclock_multi_tick     (tick_w),
    .alarmclock_multi_ring     (ring_w),
    .alarmclock_multi_ring_id  (ring_id_w)
  );

  function automatic bit bcd_ok(input logic [15:0] v);
    int h, m;
    h = int'(v[15:12]) * 10 + int'(v[11:8]);
    m = int'(v[7:4]) * 10 + int'(v[3:0]);
    return (v[15:12] <= 9) && (v[11:8] <= 9) && (v[7:4] <= 9) && (v[3:0] <= 9) &&
           (h <= 23) && (m <= 59);
  endfunction

  function automatic int to_min(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] bcd_of(input int sod);
    int h, m;
    h = sod / 3600;
    m = (sod / 60) % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic bit exp_tick();
    return en && (m_pre == TD - 1);
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit tk, roll;
    int sod_n, pre_n;
    tk = exp_tick();
    if (rst) begin
      m_sod = 0; m_pre = 0; m_mode = MIdle; m_cnt = 0; m_id = 0;
      for (int i = 0; i < NA; i++) m_slot[i] = 0;
      return;
    end
    pre_n = en ? (tk ? 0 : m_pre + 1) : m_pre;
    sod_n = m_sod;
    roll = 1'b0;
    if (set_time && bcd_ok(set_val)) begin
      sod_n = to_min(set_val) * 60;
      pre_n = 0;
    end else if (tk) begin
      roll = (m_sod % 60 == 59);
      sod_n = (m_sod + 1) % 86400;
    end
    if (m_mode == MIdle) begin
      if (roll) begin
        for (int i = NA - 1; i >= 0; i--) begin
          if (alarm_en[i] && m_slot[i] == sod_n / 60) begin
            m_mode = MRing; m_cnt = RS; m_id = i;
          end
        end
      end
    end else if (dismiss || !alarm_en[m_id]) begin
      m_mode = MIdle;
    end else if (m_mode == MRing) begin
      if (SNZ && snooze) begin
        m_mode = MSnooze; m_cnt = SM * 60;
      end else if (tk) begin
        m_cnt--;
        if (m_cnt == 0) m_mode = MIdle;
      end
    end else if (tk) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_mode = MRing; m_cnt = RS;
      end
    end
    if (set_alarm && bcd_ok(set_val) && int'(sel) < NA) m_slot[sel] = to_min(set_val);
    m_sod = sod_n;
    m_pre = pre_n;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    for (int c = 0; c < n * TD * 4 + 16 && k < n; c++) begin
      if (exp_tick()) k++;
      cyc();
    end
  endtask

  task automatic ring_up(input logic [3:0] mask);
    alarm_en = mask;
    set_val = 16'h0659; set_time = 1'b1; cyc(); set_time = 1'b0;
    run_ticks(60);
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    n_checks++; if (time_w !== 16'h0000) begin n_fail++; $display("FAIL reset_time: got %h want 0000", time_w); end
    n_checks++; if (sec_w !== 6'd0) begin n_fail++; $display("FAIL reset_sec: got %0d want 0", sec_w); end
    n_checks++; if (tick_w !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick_w); end
    n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL reset_ring: got %b want 0", ring_w); end
    n_checks++; if (ring_id_w !== 2'd0) begin n_fail++; $display("FAIL reset_ring_id: got %0d want 0", ring_id_w); end
  endtask

  task automatic test_wrap();
    int ticks = 0;
    int last = -1;
    set_val = 16'h2359; set_time = 1'b1; cyc(); set_time = 1'b0;
    for (int c = 0; c < 400 && ticks < 60; c++) begin
      n_checks++; if (tick_w !== exp_tick()) begin n_fail++; $display("FAIL wrap_tick c=%0d: got %b want %b", c, tick_w, exp_tick()); end
      if (tick_w === 1'b1) begin
        if (ticks == 59) begin
          n_checks++; if (sec_w !== 6'd59 || time_w !== 16'h2359) begin n_fail++; $display("FAIL wrap_pre: got %h:%0d want 2359:59", time_w, sec_w); end
        end
        if (last >= 0) begin
          n_checks++; if (c - last != TD) begin n_fail++; $display("FAIL wrap_period: got %0d want %0d", c - last, TD); end
        end
        last = c;
        ticks++;
      end
      cyc();
    end
    n_checks++; if (time_w !== 16'h0000 || sec_w !== 6'd0) begin n_fail++; $display("FAIL wrap_end: got %h:%0d want 0000:0", time_w, sec_w); end
  endtask

  task automatic test_priority();
    alarm_en = 4'b1010;
    set_alarm = 1'b1; set_val = 16'h0700; sel = 2'd1; cyc(); sel = 2'd3; cyc(); set_alarm = 1'b0;
    set_val = 16'h0659; set_time = 1'b1; cyc(); set_time = 1'b0;
    run_ticks(59);
    n_checks++; if (time_w !== 16'h0659 || sec_w !== 6'd59) begin n_fail++; $display("FAIL prio_pre: got %h:%0d want 0659:59", time_w, sec_w); end
    n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL prio_pre_ring: got %b want 0", ring_w); end
    for (int c = 0; c < TD && !exp_tick(); c++) cyc();
    n_checks++; if (tick_w !== 1'b1 || ring_w !== 1'b0) begin n_fail++; $display("FAIL prio_tick: got tick=%b ring=%b want 1/0", tick_w, ring_w); end
    cyc();
    n_checks++; if (ring_w !== 1'b1) begin n_fail++; $display("FAIL prio_ring: got %b want 1", ring_w); end
    n_checks++; if (ring_id_w !== 2'd1) begin n_fail++; $display("FAIL prio_id: got %0d want 1", ring_id_w); end
    n_checks++; if (time_w !== 16'h0700 || sec_w !== 6'd0) begin n_fail++; $display("FAIL prio_time: got %h:%0d want 0700:0", time_w, sec_w); end
  endtask

  task automatic test_timeout();
    run_ticks(RS - 1);
    n_checks++; if (ring_w !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: got %b want 1", ring_w); end
    run_ticks(1);
    n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL timeout_end: got %b want 0", ring_w); end
  endtask

  task automatic test_dismiss_snooze();
    int high = 0;
    ring_up(4'b1010);
    n_checks++; if (ring_w !== 1'b1) begin n_fail++; $display("FAIL dsn_ring: got %b want 1", ring_w); end
    dismiss = 1'b1; snooze = 1'b1; cyc(); dismiss = 1'b0; snooze = 1'b0;
    n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL dsn_off: got %b want 0", ring_w); end
    for (int c = 0; c < 300; c++) begin
      cyc();
      if (ring_w !== 1'b0) high++;
    end
    n_checks++; if (high != 0) begin n_fail++; $display("FAIL dsn_stay_off: got %0d ringing cycles want 0", high); end
  endtask

  task automatic test_snooze();
    ring_up(4'b1000);
    n_checks++; if (ring_w !== 1'b1 || ring_id_w !== 2'd3) begin n_fail++; $display("FAIL snz_ring: got %b id %0d want 1 id 3", ring_w, ring_id_w); end
    snooze = 1'b1; cyc(); snooze = 1'b0;
    if (SNZ) begin
      n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL snz_quiet: got %b want 0", ring_w); end
      run_ticks(SM * 60 - 1);
      n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL snz_quiet_end: got %b want 0", ring_w); end
      run_ticks(1);
      n_checks++; if (ring_w !== 1'b1 || ring_id_w !== 2'd3) begin n_fail++; $display("FAIL snz_rering: got %b id %0d want 1 id 3", ring_w, ring_id_w); end
      dismiss = 1'b1; cyc(); dismiss = 1'b0;
    end else begin
      n_checks++; if (ring_w !== 1'b1) begin n_fail++; $display("FAIL snz_ignored: got %b want 1", ring_w); end
      run_ticks(RS - 1);
      n_checks++; if (ring_w !== 1'b1) begin n_fail++; $display("FAIL snz_hold: got %b want 1", ring_w); end
      run_ticks(1);
    end
    n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL snz_end: got %b want 0", ring_w); end
  endtask

  task automatic test_disarm_freeze();
    ring_up(4'b1010);
    en = 1'b0;
    repeat (40) cyc();
    n_checks++; if (ring_w !== 1'b1 || tick_w !== 1'b0) begin n_fail++; $display("FAIL frz_ring: got ring=%b tick=%b want 1/0", ring_w, tick_w); end
    n_checks++; if (time_w !== 16'h0700 || sec_w !== 6'd0) begin n_fail++; $display("FAIL frz_time: got %h:%0d want 0700:0", time_w, sec_w); end
    alarm_en = 4'b1000; cyc();
    n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL disarm: got %b want 0", ring_w); end
    en = 1'b1;
    ring_up(4'b1010);
    en = 1'b0; dismiss = 1'b1; cyc(); dismiss = 1'b0;
    n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL frz_dismiss: got %b want 0", ring_w); end
    en = 1'b1;
  endtask

  task automatic test_invalid();
    logic [15:0] bad [5];
    bad = '{16'h2460, 16'h1A00, 16'h2400, 16'h0960, 16'h12F0};
    en = 1'b0;
    set_val = 16'h1234; set_time = 1'b1; cyc(); set_time = 1'b0;
    n_checks++; if (time_w !== 16'h1234 || sec_w !== 6'd0) begin n_fail++; $display("FAIL inv_load: got %h:%0d want 1234:0", time_w, sec_w); end
    for (int i = 0; i < 5; i++) begin
      set_val = bad[i]; set_time = 1'b1; cyc(); set_time = 1'b0;
    end
    n_checks++; if (time_w !== 16'h1234 || sec_w !== 6'd0) begin n_fail++; $display("FAIL inv_time: got %h:%0d want 1234:0", time_w, sec_w); end
    set_alarm = 1'b1; sel = 2'd0; set_val = 16'h2400; cyc();
    sel = 2'd1; set_val = 16'h07A0; cyc(); set_alarm = 1'b0;
    en = 1'b1; alarm_en = 4'b0001;
    set_val = 16'h2359; set_time = 1'b1; cyc(); set_time = 1'b0;
    run_ticks(60);
    n_checks++; if (ring_w !== 1'b1 || ring_id_w !== 2'd0) begin n_fail++; $display("FAIL inv_slot0: got %b id %0d want 1 id 0", ring_w, ring_id_w); end
    dismiss = 1'b1; cyc(); dismiss = 1'b0;
  endtask

  task automatic test_reset_ring();
    ring_up(4'b0010);
    n_checks++; if (ring_w !== 1'b1 || ring_id_w !== 2'd1) begin n_fail++; $display("FAIL rst_pre: got %b id %0d want 1 id 1", ring_w, ring_id_w); end
    rst = 1'b1; dismiss = 1'b0; set_val = 16'h1111; set_time = 1'b1; cyc(); rst = 1'b0; set_time = 1'b0;
    n_checks++; if (ring_w !== 1'b0 || ring_id_w !== 2'd0 || tick_w !== 1'b0) begin n_fail++; $display("FAIL rst_ring: got ring=%b id=%0d tick=%b want 0", ring_w, ring_id_w, tick_w); end
    n_checks++; if (time_w !== 16'h0000 || sec_w !== 6'd0) begin n_fail++; $display("FAIL rst_time: got %h:%0d want 0000:0", time_w, sec_w); end
    ring_up(4'b1111);
    n_checks++; if (ring_w !== 1'b0) begin n_fail++; $display("FAIL rst_slots: got %b want 0", ring_w); end
  endtask

  task automatic test_random();
    logic [15:0] vals [4];
    vals = '{16'h0700, 16'h0701, 16'h1300, 16'h0000};
    set_alarm = 1'b1;
    for (int i = 0; i < NA; i++) begin
      sel = 2'(i); set_val = vals[$urandom_range(0, 3)]; cyc();
    end
    set_alarm = 1'b0; alarm_en = 4'($urandom) | 4'b0001;
    for (int c = 0; c < 4000; c++) begin
      en = ($urandom_range(0, 9) != 0);
      set_time = ($urandom_range(0, 499) == 0);
      set_alarm = ($urandom_range(0, 399) == 0);
      snooze = ($urandom_range(0, 99) == 0);
      dismiss = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) alarm_en = 4'($urandom);
      sel = 2'($urandom);
      case ($urandom_range(0, 4))
        0: set_val = 16'h0659;
        1: set_val = 16'h0700;
        2: set_val = 16'h1259;
        3: set_val = 16'h2359;
        default: set_val = 16'($urandom);
      endcase
      cyc();
      n_checks++; if (time_w !== bcd_of(m_sod)) begin n_fail++; $display("FAIL rnd_time c=%0d: got %h want %h", c, time_w, bcd_of(m_sod)); end
      n_checks++; if (sec_w !== 6'(m_sod % 60)) begin n_fail++; $display("FAIL rnd_sec c=%0d: got %0d want %0d", c, sec_w, m_sod % 60); end
      n_checks++; if (tick_w !== exp_tick()) begin n_fail++; $display("FAIL rnd_tick c=%0d: got %b want %b", c, tick_w, exp_tick()); end
      n_checks++; if (ring_w !== (m_mode == MRing)) begin n_fail++; $display("FAIL rnd_ring c=%0d: got %b want %b", c, ring_w, m_mode == MRing); end
      n_checks++; if (ring_id_w !== 2'(m_id)) begin n_fail++; $display("FAIL rnd_ring_id c=%0d: got %0d want %0d", c, ring_id_w, m_id); end
    end
    set_time = 1'b0; set_alarm = 1'b0; snooze = 1'b0; dismiss = 1'b0; en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; set_time = 1'b0; set_alarm = 1'b0; sel = 2'd0;
    set_val = 16'h0000; alarm_en = 4'b0000; snooze = 1'b0; dismiss = 1'b0;
    m_sod = 0; m_pre = 0; m_mode = MIdle; m_cnt = 0; m_id = 0;
    for (int i = 0; i < NA; i++) m_slot[i] = 0;
    test_reset();
    test_wrap();
    test_priority();
    test_timeout();
    test_dismiss_snooze();
    test_snooze();
    test_disarm_freeze();
    test_invalid();
    test_reset_ring();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
